// File: rtl/game_pkg.sv
// Shared constants, FSM state type and row-pattern helper for the falling-row game.
package game_pkg;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  // Fibonacci taps 16,14,13,11 expressed as a mask over state bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {IDLE, RUN, HALT} spawn_state_t;

  function automatic logic [COLS-1:0] col_bit(input logic [3:0] nib);
    logic [3:0] idx;
    logic [COLS-1:0] r;
    idx = (nib >= 4'd10) ? nib - 4'd10 : nib;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // One obstacle from the low nibble; a second from the next nibble once hard.
  function automatic logic [COLS-1:0] row_pattern(input logic [15:0] s, input logic hard);
    logic [COLS-1:0] r;
    r = col_bit(s[3:0]);
    if (hard) r = r | col_bit(s[7:4]);
    return r;
  endfunction
endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that only moves when advance is high.
module lfsr16 import game_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [15:0] state
);
  always_ff @(posedge clk or posedge rst)
    if (rst)          state <= SEED;
    else if (advance) state <= {state[14:0], ^(state & LFSR_TAPS)};
endmodule

// File: rtl/row_spawner.sv
// Paces row drops with a level-dependent period and generates the next top row.
module row_spawner import game_pkg::*; #(
  parameter int          BASE_PERIOD = 25_000_000,
  parameter int          MIN_PERIOD  = 5_000_000,
  parameter int          PERIOD_STEP = 2_500_000,
  parameter int          LEVEL_ROWS  = 32,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic            CLK_50,
  input  logic            RESET,
  input  logic            enable,
  input  logic            end_game,
  output logic            step,
  output logic [COLS-1:0] new_row,
  output logic [2:0]      level,
  output logic [15:0]     rows_spawned
);
  localparam int CW = $clog2(BASE_PERIOD + 1);
  localparam int LW = $clog2(LEVEL_ROWS + 1);

  spawn_state_t    state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [LW-1:0]   lvl_cnt;
  logic            parity;
  logic            fire;
  logic [2:0]      level_nxt;
  logic [15:0]     lfsr_q;
  logic [COLS-1:0] row_nxt;

  function automatic logic [CW-1:0] reload_val(input logic [2:0] lv);
    int p;
    p = BASE_PERIOD - int'(lv) * PERIOD_STEP;
    if (p < MIN_PERIOD) p = MIN_PERIOD;
    return CW'(p - 1);
  endfunction

  always_ff @(posedge CLK_50 or posedge RESET)
    if (RESET) state <= IDLE;
    else       state <= state_nxt;

  // end_game outranks everything, including a drop that is due this cycle.
  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    unique case (state)
      IDLE: if (end_game) state_nxt = HALT;
            else if (enable) state_nxt = RUN;
      RUN: begin
        if (end_game) state_nxt = HALT;
        else begin
          fire = (cnt == '0);
          if (!enable) state_nxt = IDLE;
        end
      end
      HALT: ;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    level_nxt = level;
    if (fire && lvl_cnt == LW'(LEVEL_ROWS - 1) && level != 3'd7) level_nxt = level + 3'd1;
  end

  assign row_nxt = parity ? row_pattern(lfsr_q, level >= 3'd2) : '0;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk     (CLK_50),
    .rst     (RESET),
    .advance (fire),
    .state   (lfsr_q)
  );

  // The reload uses the post-step level so a level change shortens the very next interval.
  always_ff @(posedge CLK_50 or posedge RESET)
    if (RESET) begin
      cnt          <= CW'(BASE_PERIOD - 1);
      step         <= 1'b0;
      new_row      <= '0;
      level        <= '0;
      rows_spawned <= '0;
      parity       <= 1'b0;
      lvl_cnt      <= '0;
    end else begin
      step <= fire;
      if (state == RUN && !end_game) cnt <= fire ? reload_val(level_nxt) : cnt - CW'(1);
      if (fire) begin
        parity  <= ~parity;
        new_row <= row_nxt;
        level   <= level_nxt;
        lvl_cnt <= (lvl_cnt == LW'(LEVEL_ROWS - 1)) ? '0 : lvl_cnt + LW'(1);
        if (rows_spawned != 16'hFFFF) rows_spawned <= rows_spawned + 16'd1;
      end
    end
endmodule

// File: tb/tb_row_spawner.sv
// Randomized scoreboard bench for row_spawner against a step-counting reference model.
module tb_row_spawner;
  localparam int          BP = 8, MP = 2, PS = 2, LR = 4;
  localparam logic [15:0] SD = 16'hACE1;

  logic        CLK_50 = 1'b0, RESET = 1'b0, enable = 1'b0, end_game = 1'b0;
  logic        step;
  logic [9:0]  new_row;
  logic [2:0]  level;
  logic [15:0] rows_spawned;

  row_spawner #(.BASE_PERIOD(BP), .MIN_PERIOD(MP), .PERIOD_STEP(PS), .LEVEL_ROWS(LR), .SEED(SD)) dut (
    .CLK_50(CLK_50), .RESET(RESET), .enable(enable), .end_game(end_game),
    .step(step), .new_row(new_row), .level(level), .rows_spawned(rows_spawned)
  );

  always #5 CLK_50 = ~CLK_50;

  typedef struct { int cyc; logic [9:0] row; logic [2:0] lvl; logic [15:0] cnt; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0;
  int run_start = 0, first_step = -1;
  int rec_t[$];
  logic [9:0] rec_r[$];

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // The game is "running" for some number of cycles; every period-th running cycle is a drop.
  bit m_run, m_halt;
  int m_elapsed, m_period, m_steps;
  logic [15:0] m_lfsr;
  exp_t m_e;

  function automatic int level_of(int n);
    return (n / LR > 7) ? 7 : n / LR;
  endfunction
  function automatic int period_for(int lv);
    int p = BP - lv * PS;
    return (p < MP) ? MP : p;
  endfunction
  function automatic logic [15:0] lfsr_next(logic [15:0] s);
    int fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
    return {s[14:0], fb[0]};
  endfunction

  always @(posedge CLK_50) begin
    cyc++;
    if (RESET) begin
      m_run = 0; m_halt = 0; m_elapsed = 0; m_period = BP; m_steps = 0; m_lfsr = SD;
    end else if (!m_halt) begin
      if (end_game) m_halt = 1;
      else if (!m_run) begin
        if (enable) m_run = 1;
      end else begin
        m_elapsed++;
        if (m_elapsed == m_period) begin
          m_steps++;
          m_e.row = '0;
          if (m_steps % 2 == 0) begin
            m_e.row[m_lfsr[3:0] % 10] = 1'b1;
            if (level_of(m_steps - 1) >= 2) m_e.row[m_lfsr[7:4] % 10] = 1'b1;
          end
          m_lfsr    = lfsr_next(m_lfsr);
          m_e.cyc   = cyc;
          m_e.lvl   = 3'(level_of(m_steps));
          m_e.cnt   = (m_steps > 65535) ? 16'hFFFF : 16'(m_steps);
          sb.push_back(m_e);
          m_elapsed = 0;
          m_period  = period_for(level_of(m_steps));
        end
        if (!enable) m_run = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge CLK_50) begin
    exp_t e;
    if (RESET) sb.delete();
    else begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("step_missing_cycle", 0, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (step) begin
        if (sb.size() == 0 || sb[0].cyc != cyc) chk("unexpected_step", cyc, (sb.size() == 0) ? -1 : sb[0].cyc);
        else begin
          e = sb.pop_front();
          chk("new_row", new_row, e.row);
          chk("level_at_step", level, e.lvl);
          chk("rows_spawned", rows_spawned, e.cnt);
          if (e.cnt[0] == 1'b0) chk("row_bits_1_or_2", ($countones(new_row) inside {[1:2]}) ? 1 : 0, 1);
        end
        if (first_step < 0) first_step = cyc;
        rec_t.push_back(cyc - run_start);
        rec_r.push_back(new_row);
      end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
        chk("step_absent", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK_50);
    #1;
  endtask

  // Reset raised mid-cycle so the asynchronous clear is visible before any edge.
  task automatic do_reset();
    #3 RESET = 1'b1;
    enable = 1'b0;
    end_game = 1'b0;
    #1;
    chk("async_rst_step", step, 0);
    chk("async_rst_rows", rows_spawned, 0);
    tick(2);
    RESET = 1'b0;
    run_start = cyc;
    first_step = -1;
    rec_t.delete();
    rec_r.delete();
  endtask

  int a_t[$];
  logic [9:0] a_r[$];
  logic [9:0] fz_row;
  logic [2:0] fz_lvl;
  logic [15:0] fz_cnt;
  int frozen_bad;
  bit armed;

  initial begin
    RESET = 1'b1;
    tick(2);
    chk("reset_step", step, 0);
    chk("reset_new_row", new_row, 0);
    chk("reset_level", level, 0);
    chk("reset_rows_spawned", rows_spawned, 0);
    RESET = 1'b0;
    run_start = cyc;

    // Run A from power-on: first drop lands BP cycles after the first RUN cycle.
    enable = 1'b1;
    tick(60);
    enable = 1'b0;
    chk("first_step_latency", first_step - run_start, 1 + BP);
    a_t = rec_t;
    a_r = rec_r;

    // Run B: reset mid-period, then identical stimulus must replay identically.
    enable = 1'b1;
    tick(13);
    do_reset();
    enable = 1'b1;
    tick(60);
    enable = 1'b0;
    chk("replay_count", rec_t.size(), a_t.size());
    if (rec_t.size() == a_t.size())
      foreach (a_t[i]) begin
        chk("replay_time", rec_t[i], a_t[i]);
        chk("replay_row", rec_r[i], a_r[i]);
      end

    // Pause: 3 RUN cycles, 5 cycles disabled -> first drop 5 cycles late.
    do_reset();
    enable = 1'b1;
    tick(4);
    enable = 1'b0;
    tick(5);
    enable = 1'b1;
    tick(20);
    chk("pause_step_latency", first_step - run_start, 1 + BP + 5);

    // Long run to level saturation.
    tick(150);
    chk("level_saturated", level, 7);
    chk("rows_vs_model", rows_spawned, m_steps);

    // Random enable pattern.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 9) < 8);
      tick(1);
    end
    chk("random_rows_vs_model", rows_spawned, m_steps);
    chk("random_level_vs_model", level, level_of(m_steps));

    // end_game in a would-be drop cycle: no drop, then frozen until reset.
    do_reset();
    enable = 1'b1;
    armed = 0;
    for (int i = 0; i < 300 && !armed; i++) begin
      tick(1);
      armed = m_run && m_steps >= 5 && m_elapsed == m_period - 1;
    end
    chk("endgame_armed", armed, 1);
    fz_cnt = rows_spawned;
    end_game = 1'b1;
    tick(1);
    end_game = 1'b0;
    chk("endgame_suppresses_step", step, 0);
    chk("endgame_no_count", rows_spawned, fz_cnt);
    fz_row = new_row;
    fz_lvl = level;
    frozen_bad = 0;
    for (int i = 0; i < 100; i++) begin
      enable = $urandom_range(0, 1);
      end_game = $urandom_range(0, 1);
      tick(1);
      if (step !== 1'b0 || new_row !== fz_row || level !== fz_lvl || rows_spawned !== fz_cnt) frozen_bad++;
    end
    chk("halt_frozen_cycles_bad", frozen_bad, 0);
    do_reset();
    chk("post_halt_new_row", new_row, 0);
    chk("post_halt_level", level, 0);
    enable = 1'b1;
    tick(12);
    chk("post_halt_restart_steps", rows_spawned, 1);
    enable = 1'b0;
    tick(2);

    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=%0d required=finish", cyc);
    $fatal(1);
  end
endmodule
